// File: rtl/seg_595_rx.sv
`default_nettype none
// ============================================================================
//  Module   : seg_595_rx
//  Purpose  : Receives the serial stream a 74HC595-style driver sends to a
//             7-segment display and recovers the latched segment pattern and
//             digit select. All control inputs are asynchronous to sys_clk
//             and are synchronized before edge detection.
//  Ports    : sys_clk, sys_rst_n (async, active-low)
//             shcp / stcp / ds / oe  - raw 595 bus (asynchronous)
//             seg[7:0]  - latched pattern, common-anode, 8'hFF when blanked
//             sel[5:0]  - latched one-hot digit select, 0 when blanked
//             frame_valid - 1-cycle pulse per stcp rising edge
//             bit_err     - 1-cycle pulse with frame_valid when the frame
//                           did not contain exactly FRAME_BITS shifts
//             disp_on     - synchronized inverse of oe
//  Option   : `define SEG_595_RX_DECODE_EN adds hex_val[3:0], digit_idx[2:0]
//             and dec_err, decoded from the frame as it is latched.
//  Revision : 1.0  initial release
// ============================================================================
module seg_595_rx #(
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int FRAME_BITS  = 14   // 8 seg + 6 sel
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       shcp,
  input  logic       stcp,
  input  logic       ds,
  input  logic       oe,
  output logic [7:0] seg,
  output logic [5:0] sel,
  output logic       frame_valid,
  output logic       bit_err,
  output logic       disp_on
`ifdef SEG_595_RX_DECODE_EN
  ,
  output logic [3:0] hex_val,
  output logic [2:0] digit_idx,
  output logic       dec_err
`endif
);

  localparam logic [4:0] c_frame_cnt = 5'(FRAME_BITS);
  localparam logic [4:0] c_cnt_max   = 5'd31;

  // Bit order of the synchronizer bank: {oe, ds, stcp, shcp}. ds shares the
  // depth of shcp so data and its strobe stay aligned after synchronization.
  logic [3:0] w_async_in;
  logic [3:0] w_sync;

  assign w_async_in = {oe, ds, stcp, shcp};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_chain;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_chain <= '0;
        else            r_chain <= {r_chain[SYNC_STAGES-2:0], w_async_in[gi]};
      end
      assign w_sync[gi] = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  logic w_shcp_s, w_stcp_s, w_ds_s, w_oe_s;
  assign {w_oe_s, w_ds_s, w_stcp_s, w_shcp_s} = w_sync;

  // One extra registered copy for rising-edge detection.
  logic r_shcp_q, r_stcp_q;
  logic w_shcp_rise, w_stcp_rise;

  assign w_shcp_rise = w_shcp_s & ~r_shcp_q;
  assign w_stcp_rise = w_stcp_s & ~r_stcp_q;

  logic [FRAME_BITS-1:0] r_shreg;
  logic [FRAME_BITS-1:0] r_store;
  logic [4:0]            r_bit_cnt;

`ifdef SEG_595_RX_DECODE_EN
  logic [3:0] w_hex,  r_hex;
  logic [2:0] w_dig,  r_dig;
  logic       w_dec_err, r_dec_err;
  logic       w_seg_hit, w_sel_hit;

  // Decode the shift register contents, which is exactly what storage
  // captures on an stcp edge, so the decode lands in the same cycle.
  always_comb begin
    w_hex     = 4'd0;
    w_seg_hit = 1'b1;
    case (r_shreg[6:0])   // seg[7] (dot) ignored
      7'h40: w_hex = 4'h0;
      7'h79: w_hex = 4'h1;
      7'h24: w_hex = 4'h2;
      7'h30: w_hex = 4'h3;
      7'h19: w_hex = 4'h4;
      7'h12: w_hex = 4'h5;
      7'h02: w_hex = 4'h6;
      7'h78: w_hex = 4'h7;
      7'h00: w_hex = 4'h8;
      7'h10: w_hex = 4'h9;
      7'h08: w_hex = 4'hA;
      7'h03: w_hex = 4'hB;
      7'h46: w_hex = 4'hC;
      7'h21: w_hex = 4'hD;
      7'h06: w_hex = 4'hE;
      7'h0E: w_hex = 4'hF;
      default: w_seg_hit = 1'b0;
    endcase
    w_dig     = 3'd0;
    w_sel_hit = 1'b1;
    case (r_shreg[FRAME_BITS-1:8])
      6'b000001: w_dig = 3'd0;
      6'b000010: w_dig = 3'd1;
      6'b000100: w_dig = 3'd2;
      6'b001000: w_dig = 3'd3;
      6'b010000: w_dig = 3'd4;
      6'b100000: w_dig = 3'd5;
      default:   w_sel_hit = 1'b0;
    endcase
    w_dec_err = ~(w_seg_hit & w_sel_hit);
    if (w_dec_err) begin
      w_hex = 4'd0;
      w_dig = 3'd0;
    end
  end

  assign hex_val   = r_hex;
  assign digit_idx = r_dig;
  assign dec_err   = r_dec_err;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shcp_q    <= 1'b0;
      r_stcp_q    <= 1'b0;
      r_shreg     <= '0;
      // Storage resets to the blank pattern so seg reads 8'hFF out of reset.
      r_store     <= {{(FRAME_BITS-8){1'b0}}, 8'hFF};
      r_bit_cnt   <= 5'd0;
      frame_valid <= 1'b0;
      bit_err     <= 1'b0;
`ifdef SEG_595_RX_DECODE_EN
      r_hex       <= 4'd0;
      r_dig       <= 3'd0;
      r_dec_err   <= 1'b0;
`endif
    end else begin
      r_shcp_q    <= w_shcp_s;
      r_stcp_q    <= w_stcp_s;
      frame_valid <= w_stcp_rise;
      bit_err     <= w_stcp_rise && (r_bit_cnt != c_frame_cnt);

      if (w_shcp_rise)
        r_shreg <= {r_shreg[FRAME_BITS-2:0], w_ds_s};

      // Non-blocking update: a coincident shift is not yet visible here,
      // so storage takes the pre-shift contents like a real 74HC595.
      if (w_stcp_rise) begin
        r_store   <= r_shreg;
        r_bit_cnt <= w_shcp_rise ? 5'd1 : 5'd0;
`ifdef SEG_595_RX_DECODE_EN
        r_hex     <= w_hex;
        r_dig     <= w_dig;
        r_dec_err <= w_dec_err;
`endif
      end else if (w_shcp_rise && (r_bit_cnt != c_cnt_max)) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  // Blanking only masks the outputs; storage is kept and reappears.
  assign disp_on = ~w_oe_s;
  assign seg     = disp_on ? r_store[7:0]            : 8'hFF;
  assign sel     = disp_on ? r_store[FRAME_BITS-1:8] : 6'b000000;

endmodule
`default_nettype wire

// File: tb/tb_seg_595_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_595_rx
//  Purpose  : Self-checking bench for seg_595_rx. A queue-based model keeps
//             the last received bits and the shift count since the last
//             latch; expected frames are rebuilt from that history.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_595_rx;

  localparam int S    = 2;
  localparam int HALF = 4;   // shcp/stcp high/low time in sys_clk cycles

  localparam logic [7:0] PATS [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                       8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                       8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       shcp = 1'b0, stcp = 1'b0, ds = 1'b0, oe = 1'b0;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       frame_valid, bit_err, disp_on;
`ifdef SEG_595_RX_DECODE_EN
  logic [3:0] hex_val;
  logic [2:0] digit_idx;
  logic       dec_err;
`endif

  seg_595_rx #(.SYNC_STAGES(S), .FRAME_BITS(14)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .shcp        (shcp),
    .stcp        (stcp),
    .ds          (ds),
    .oe          (oe),
    .seg         (seg),
    .sel         (sel),
    .frame_valid (frame_valid),
    .bit_err     (bit_err),
    .disp_on     (disp_on)
`ifdef SEG_595_RX_DECODE_EN
    ,
    .hex_val     (hex_val),
    .digit_idx   (digit_idx),
    .dec_err     (dec_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  bit m_q[$];     // most recent bits, oldest first
  int m_cnt;      // shifts since last latch

  function automatic void m_reset();
    m_q.delete();
    m_cnt = 0;
  endfunction

  function automatic void m_push(input bit b);
    m_q.push_back(b);
    if (m_q.size() > 14) void'(m_q.pop_front());
    m_cnt++;
  endfunction

  // First-received bit of the last 14 lands in the MSB; missing bits are 0.
  function automatic logic [13:0] m_frame();
    logic [13:0] f = '0;
    int n = m_q.size();
    for (int i = 0; i < 14; i++) begin
      int idx = n - 14 + i;
      if (idx >= 0) f[13-i] = m_q[idx];
    end
    return f;
  endfunction

  function automatic void dec_model(input logic [13:0] f, output logic [3:0] h,
                                    output logic [2:0] d, output logic e);
    bit found = 0;
    h = 4'd0;
    d = 3'd0;
    for (int k = 0; k < 16; k++)
      if (PATS[k][6:0] == f[6:0]) begin found = 1; h = 4'(k); end
    for (int k = 0; k < 6; k++)
      if (f[8+k]) d = 3'(k);
    e = !found || ($countones(f[13:8]) != 1);
    if (e) begin h = 4'd0; d = 3'd0; end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input bit b);
    ds = b;
    wait_clks(HALF);
    shcp = 1'b1;
    m_push(b);
    wait_clks(HALF);
    shcp = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // Raises stcp (optionally together with shcp) and watches the outputs.
  task automatic do_latch(input bit with_shift, input bit b,
                          output int fv, output int lat,
                          output logic err, output logic spur);
    fv = 0; lat = -1; err = 1'b0; spur = 1'b0;
    if (with_shift) begin
      ds = b;
      wait_clks(HALF);
      shcp = 1'b1;
    end else begin
      wait_clks(HALF);
    end
    stcp = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge sys_clk);
      if (frame_valid) begin
        fv++;
        if (lat < 0) lat = i;
        err = bit_err;
      end else if (bit_err) spur = 1'b1;
    end
    shcp = 1'b0;
    stcp = 1'b0;
    wait_clks(HALF);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0;
    m_reset();
    wait_clks(3);
    n_vec++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg: got %h want ff", seg); end
    n_vec++; if (sel !== 6'b0) begin n_bad++; $display("FAIL reset_sel: got %b want 000000", sel); end
    n_vec++; if (frame_valid !== 1'b0 || bit_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: fv=%b be=%b want 0 0", frame_valid, bit_err); end
    n_vec++; if (disp_on !== 1'b1) begin n_bad++; $display("FAIL reset_disp_on: got %b want 1", disp_on); end
    sys_rst_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_basic();
    int fv, lat; logic err, spur; logic [13:0] f;
    send_word({18'd0, 6'b000001, 8'hC0}, 14);
    f = m_frame();
    do_latch(0, 0, fv, lat, err, spur);
    m_cnt = 0;
    n_vec++; if (fv !== 1) begin n_bad++; $display("FAIL basic_fv_count: got %0d want 1", fv); end
    n_vec++; if (lat !== S + 1) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, S + 1); end
    n_vec++; if (err !== 1'b0 || spur !== 1'b0) begin
      n_bad++; $display("FAIL basic_bit_err: got %b/%b want 0/0", err, spur); end
    n_vec++; if (seg !== 8'hC0 || sel !== 6'b000001 || f !== {6'b000001, 8'hC0}) begin
      n_bad++; $display("FAIL basic_frame: got %b/%h want 000001/c0", sel, seg); end
`ifdef SEG_595_RX_DECODE_EN
    n_vec++; if (hex_val !== 4'd0 || digit_idx !== 3'd0 || dec_err !== 1'b0) begin
      n_bad++; $display("FAIL basic_decode: got %h/%0d/%b want 0/0/0", hex_val, digit_idx, dec_err); end
`endif
  endtask

  task automatic test_short_frame();
    int fv, lat; logic err, spur; logic [13:0] f;
    send_word(32'($urandom), 12);
    f = m_frame();
    do_latch(0, 0, fv, lat, err, spur);
    m_cnt = 0;
    n_vec++; if (fv !== 1 || err !== 1'b1) begin
      n_bad++; $display("FAIL short_err: fv=%0d be=%b want 1 1", fv, err); end
    n_vec++; if ({sel, seg} !== f) begin
      n_bad++; $display("FAIL short_frame: got %h want %h", {sel, seg}, f); end
    send_word({18'd0, 6'b001000, 8'hB0}, 14);
    do_latch(0, 0, fv, lat, err, spur);
    m_cnt = 0;
    n_vec++; if (fv !== 1 || err !== 1'b0 || {sel, seg} !== {6'b001000, 8'hB0}) begin
      n_bad++; $display("FAIL short_recover: fv=%0d be=%b frame=%h want 1 0 %h",
                        fv, err, {sel, seg}, {6'b001000, 8'hB0}); end
  endtask

  task automatic test_long_frame();
    int fv, lat; logic err, spur;
    send_word({16'd0, 2'b11, 6'b100000, 8'h92}, 16);
    do_latch(0, 0, fv, lat, err, spur);
    m_cnt = 0;
    n_vec++; if (sel !== 6'b100000 || seg !== 8'h92) begin
      n_bad++; $display("FAIL long_frame: got %b/%h want 100000/92", sel, seg); end
    n_vec++; if (fv !== 1 || err !== 1'b1) begin
      n_bad++; $display("FAIL long_err: fv=%0d be=%b want 1 1", fv, err); end
  endtask

  task automatic test_oe();
    int fv, lat; logic err, spur;
    send_word({18'd0, 6'b000100, 8'hA4}, 14);
    do_latch(0, 0, fv, lat, err, spur);
    m_cnt = 0;
    oe = 1'b1;
    wait_clks(S + 2);
    n_vec++; if (seg !== 8'hFF || sel !== 6'b0 || disp_on !== 1'b0) begin
      n_bad++; $display("FAIL oe_blank: got %h/%b/%b want ff/000000/0", seg, sel, disp_on); end
    oe = 1'b0;
    wait_clks(S + 2);
    n_vec++; if (seg !== 8'hA4 || sel !== 6'b000100 || disp_on !== 1'b1) begin
      n_bad++; $display("FAIL oe_restore: got %h/%b/%b want a4/000100/1", seg, sel, disp_on); end
  endtask

  task automatic test_reset_mid_frame();
    int fv, lat; logic err, spur; logic [13:0] f;
    send_word(32'h7F, 7);
    sys_rst_n = 1'b0;
    m_reset();
    wait_clks(2);
    n_vec++; if (seg !== 8'hFF || sel !== 6'b0) begin
      n_bad++; $display("FAIL midrst_clear: got %h/%b want ff/000000", seg, sel); end
    sys_rst_n = 1'b1;
    wait_clks(2);
    send_word(32'h55, 7);
    f = m_frame();
    do_latch(0, 0, fv, lat, err, spur);
    m_cnt = 0;
    n_vec++; if (fv !== 1 || err !== 1'b1 || {sel, seg} !== f) begin
      n_bad++; $display("FAIL midrst_frame: fv=%0d be=%b frame=%h want 1 1 %h",
                        fv, err, {sel, seg}, f); end
  endtask

  task automatic test_simultaneous();
    int fv, lat; logic err, spur; logic [13:0] f;
    bit b = 1'b1;
    send_word({18'd0, 6'b010000, 8'h99}, 14);
    f = m_frame();          // pre-shift contents
    do_latch(1, b, fv, lat, err, spur);
    m_cnt = 0;
    m_push(b);              // count restarts at 1
    n_vec++; if ({sel, seg} !== f || fv !== 1 || err !== 1'b0) begin
      n_bad++; $display("FAIL simul_preshift: frame=%h fv=%0d be=%b want %h 1 0",
                        {sel, seg}, fv, err, f); end
    send_word(32'($urandom), 13);
    f = m_frame();
    do_latch(0, 0, fv, lat, err, spur);
    n_vec++; if (err !== (m_cnt != 14) || {sel, seg} !== f) begin
      n_bad++; $display("FAIL simul_count: be=%b frame=%h want %b %h",
                        err, {sel, seg}, (m_cnt != 14), f); end
    m_cnt = 0;
  endtask

  task automatic test_random();
    int fv, lat, n; logic err, spur; logic [13:0] f; logic exp_err;
    logic [3:0] eh; logic [2:0] ed; logic ee;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) n = 14; else n = $urandom_range(0, 18);
      if ($urandom_range(0, 2) == 0)
        send_word({18'd0, 6'(1 << $urandom_range(0, 5)), PATS[$urandom_range(0, 15)]}, n);
      else
        send_word(32'($urandom), n);
      f = m_frame();
      exp_err = (m_cnt != 14);
      dec_model(f, eh, ed, ee);
      do_latch(0, 0, fv, lat, err, spur);
      m_cnt = 0;
      n_vec++;
      if (fv !== 1 || lat !== S + 1 || err !== exp_err || spur !== 1'b0 || {sel, seg} !== f) begin
        n_bad++;
        $display("FAIL rand_%0d n=%0d: fv=%0d lat=%0d be=%b sp=%b frame=%h want 1 %0d %b 0 %h",
                 it, n, fv, lat, err, spur, {sel, seg}, S + 1, exp_err, f);
      end
`ifdef SEG_595_RX_DECODE_EN
      n_vec++;
      if (hex_val !== eh || digit_idx !== ed || dec_err !== ee) begin
        n_bad++;
        $display("FAIL rand_dec_%0d: got %h/%0d/%b want %h/%0d/%b",
                 it, hex_val, digit_idx, dec_err, eh, ed, ee);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frame();
    test_long_frame();
    test_oe();
    test_reset_mid_frame();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit, got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/seg_595_rx.md
SEG_595_RX -- requirements
Module: seg_595_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each serial input; legal values 2..4.
REQ-002 Parameter FRAME_BITS, default 14, number of serial bits per frame; fixed at 14 (8 seg + 6 sel).
REQ-003 sys_clk  input  1  single clock; all state is clocked on its rising edge.
REQ-004 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 shcp  input  1  serial shift clock from the 595 driver; asynchronous to sys_clk.
REQ-006 stcp  input  1  storage latch clock from the 595 driver; asynchronous to sys_clk.
REQ-007 ds  input  1  serial data, valid at the shcp rising edge.
REQ-008 oe  input  1  output enable, active-low (0 = display on).
REQ-009 seg  output  8  latched segment pattern, common-anode (0 = segment lit).
REQ-010 sel  output  6  latched digit select, one-hot, active-high.
REQ-011 frame_valid  output  1  one-cycle pulse when a new frame is latched.
REQ-012 bit_err  output  1  one-cycle pulse, coincident with frame_valid, when the latched frame did not contain exactly FRAME_BITS shifts.
REQ-013 disp_on  output  1  synchronized inverse of oe.

Function
REQ-014 shcp, stcp, ds and oe SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized value against one further registered copy.
REQ-015 On each detected shcp rising edge: shift register shreg[13:0] <= {shreg[12:0], ds_sync}; ds SHALL use the same synchronizer depth as shcp.
REQ-016 Bit order: the first bit received SHALL end up in shreg[13]; frame mapping is shreg[13:8] = sel[5:0], shreg[7:0] = seg[7:0].
REQ-017 Bit counter bit_cnt (5 bits) SHALL increment on each shcp edge and saturate at 31; more than 14 shifts discard the oldest bits.
REQ-018 On each detected stcp rising edge: the storage register SHALL load shreg; frame_valid pulses; bit_err pulses if bit_cnt != 14; bit_cnt clears to 0.
REQ-019 Simultaneous shcp and stcp edges in one cycle: storage SHALL capture the pre-shift shreg (74HC595 behaviour); the shift then occurs and bit_cnt becomes 1.
REQ-020 Latency: seg/sel/frame_valid SHALL update at the SYNC_STAGES-th sys_clk edge after the edge that first samples stcp high.
REQ-021 When disp_on = 0, seg SHALL read 8'hFF and sel 6'b000000; the storage register SHALL be retained and reappear when disp_on returns to 1.
REQ-022 shcp/stcp high or low times below SYNC_STAGES+1 sys_clk periods are unsupported; no detection is guaranteed.
REQ-023 stcp rising with no preceding shifts SHALL re-latch the unchanged shreg and assert bit_err.

Reset
REQ-024 sys_rst_n low SHALL asynchronously clear synchronizers (to 0), shreg, storage, bit_cnt, frame_valid, bit_err.
REQ-025 Output reset values: seg = 8'hFF, sel = 6'b000000, frame_valid = 0, bit_err = 0, disp_on = 1.
REQ-026 Reset mid-frame SHALL discard partial bits; the first stcp after release with fewer than 14 shifts SHALL flag bit_err.
REQ-027 Deassertion is synchronized externally; the block adds no reset synchronizer.

Configuration
REQ-028 Macro SEG_595_RX_DECODE_EN: when defined, the block SHALL add outputs hex_val[3:0], digit_idx[2:0] and dec_err, registered at the same cycle as seg/sel.
REQ-029 With the macro: hex_val SHALL decode common-anode patterns 8'hC0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E to 0..F, ignoring seg[7] (dot); digit_idx = index of the set sel bit (0..5).
REQ-030 With the macro: dec_err = 1 when seg[6:0] matches no pattern or sel is not one-hot; hex_val and digit_idx then read 0.
REQ-031 Without the macro: these ports and logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-032 Reset, then 14 shcp pulses sending sel=6'b000001, seg=8'hC0, then stcp -> seg=8'hC0, sel=6'b000001, one frame_valid, bit_err=0 (decode: hex_val=0, digit_idx=0).
REQ-033 Send 12 bits then stcp -> frame_valid and bit_err pulse together; next clean 14-bit frame -> bit_err=0.
REQ-034 Send 16 bits, last 14 encoding sel=6'b100000, seg=8'h92 -> sel=6'b100000, seg=8'h92, bit_err=1.
REQ-035 Latched frame sel=6'b000100/seg=8'hA4, oe=1 -> seg=8'hFF, sel=0, disp_on=0; oe=0 -> 8'hA4/6'b000100 restored.
REQ-036 Assert sys_rst_n low after 7 shifts, release, send 7 bits, stcp -> bit_err=1; shcp and stcp edges in the same cycle -> storage holds pre-shift value, bit_cnt=1.
